// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship shot controller.
// Latency: none (types, constants and a pure decode function only).
// Backpressure: not applicable.
package battleship_pkg;

  localparam int BOARD_DIM      = 10;
  localparam int RESULT_LAT_DEF = 1;
  localparam int BIG_SHOTS_DEF  = 3;
  localparam int MAX_SHOTS_DEF  = 60;
  localparam int WIN_HITS_DEF   = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_REPORT,
    ST_OVER
  } shot_state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_HIT,
    RES_NEAR,
    RES_MISS
  } shot_result_t;

  // A verdict is only meaningful when exactly one flag is raised.
  function automatic shot_result_t decode_verdict(input logic hit,
                                                  input logic near,
                                                  input logic miss);
    shot_result_t res;
    case ({hit, near, miss})
      3'b100:  res = RES_HIT;
      3'b010:  res = RES_NEAR;
      3'b001:  res = RES_MISS;
      default: res = RES_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/battleship_shot_ctrl_edge_detect.sv
// Rising-edge detector for the already-synchronised fire level.
// Latency: pulse is combinational from the input in the cycle the level rises.
// Backpressure: none; a held level yields exactly one pulse.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Previous-cycle sample of the level.
  always_comb begin
    prev_d = sig_in;
  end

  // Previous-value register, cleared so a level high out of reset still fires once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  assign rise = sig_in & ~prev_q;

endmodule

// File: rtl/battleship_shot_ctrl.sv
// Turn sequencer: validates fire requests, strobes the scorer, captures the verdict, tracks budgets.
// Latency: fire event in t -> score_this in t+1 -> result_valid in t+2+RESULT_LAT.
// Backpressure: ready is low from ISSUE until back in IDLE; fire events outside IDLE are dropped.
module battleship_shot_ctrl
  import battleship_pkg::*;
#(
  parameter int RESULT_LAT = RESULT_LAT_DEF,
  parameter int BIG_SHOTS  = BIG_SHOTS_DEF,
  parameter int MAX_SHOTS  = MAX_SHOTS_DEF,
  parameter int WIN_HITS   = WIN_HITS_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       fire,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       big,
  input  logic       sc_hit,
  input  logic       sc_near_miss,
  input  logic       sc_miss,
  input  logic       sc_something_wrong,
  output logic       score_this,
  output logic [3:0] sc_x,
  output logic [3:0] sc_y,
  output logic       sc_big,
  output logic [1:0] sc_big_left,
  output logic       ready,
  output logic       result_valid,
  output logic       last_hit,
  output logic       last_near_miss,
  output logic       last_miss,
  output logic       reject,
  output logic [6:0] shots_left,
  output logic [4:0] hit_count,
  output logic       game_over,
  output logic       win,
  output logic       error
);

  shot_state_t  state_q, state_d;
  logic [1:0]   wait_cnt_q, wait_cnt_d;
  logic [3:0]   sc_x_q, sc_x_d;
  logic [3:0]   sc_y_q, sc_y_d;
  logic         sc_big_q, sc_big_d;
  logic [1:0]   big_left_q, big_left_d;
  logic [6:0]   shots_left_q, shots_left_d;
  logic [4:0]   hit_count_q, hit_count_d;
  shot_result_t last_q, last_d;
  logic         win_q, win_d;
  logic         error_q, error_d;
  logic         reject_q, reject_d;

  logic         fire_rise;
  logic         shot_ok;
  logic         wait_done;
  logic         verdict_ok;
  shot_result_t verdict;

  edge_detect u_fire_edge (
    .clock  (clock),
    .reset  (reset),
    .sig_in (fire),
    .rise   (fire_rise)
  );

  // Shot legality, verdict decode and the WAIT terminal-count flag.
  always_comb begin
    shot_ok    = (x < 4'(BOARD_DIM)) && (y < 4'(BOARD_DIM)) && (!big || (big_left_q != 2'd0));
    verdict    = decode_verdict(sc_hit, sc_near_miss, sc_miss);
    verdict_ok = (verdict != RES_NONE) && !sc_something_wrong;
    wait_done  = (wait_cnt_q == 2'd0);
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 2'd0;
      sc_x_q       <= 4'd0;
      sc_y_q       <= 4'd0;
      sc_big_q     <= 1'b0;
      big_left_q   <= 2'(BIG_SHOTS);
      shots_left_q <= 7'(MAX_SHOTS);
      hit_count_q  <= 5'd0;
      last_q       <= RES_NONE;
      win_q        <= 1'b0;
      error_q      <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      sc_x_q       <= sc_x_d;
      sc_y_q       <= sc_y_d;
      sc_big_q     <= sc_big_d;
      big_left_q   <= big_left_d;
      shots_left_q <= shots_left_d;
      hit_count_q  <= hit_count_d;
      last_q       <= last_d;
      win_q        <= win_d;
      error_q      <= error_d;
      reject_q     <= reject_d;
    end
  end

  // Next-state logic; new_game overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fire_rise && shot_ok) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_WAIT;
      ST_WAIT:   if (wait_done) state_d = verdict_ok ? ST_REPORT : ST_OVER;
      ST_REPORT: begin
        if (hit_count_q == 5'(WIN_HITS))  state_d = ST_OVER;
        else if (shots_left_q == 7'd0)    state_d = ST_OVER;
        else                              state_d = ST_IDLE;
      end
      ST_OVER:   state_d = ST_OVER;
      default:   state_d = ST_IDLE;
    endcase
    if (new_game) state_d = ST_IDLE;
  end

  // Datapath updates. Budgets are charged on acceptance so that sc_big_left
  // already shows the post-shot value in ISSUE and holds through WAIT.
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    sc_x_d       = sc_x_q;
    sc_y_d       = sc_y_q;
    sc_big_d     = sc_big_q;
    big_left_d   = big_left_q;
    shots_left_d = shots_left_q;
    hit_count_d  = hit_count_q;
    last_d       = last_q;
    win_d        = win_q;
    error_d      = error_q;
    reject_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire_rise) begin
          if (shot_ok) begin
            sc_x_d       = x;
            sc_y_d       = y;
            sc_big_d     = big;
            shots_left_d = (shots_left_q != 7'd0) ? shots_left_q - 7'd1 : 7'd0;
            if (big) big_left_d = big_left_q - 2'd1;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_ISSUE: wait_cnt_d = 2'(RESULT_LAT - 1);
      ST_WAIT: begin
        if (!wait_done) begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end else if (verdict_ok) begin
          last_d = verdict;
          if (verdict == RES_HIT) hit_count_d = hit_count_q + 5'd1;
        end else begin
          error_d = 1'b1;
        end
      end
      ST_REPORT: if (hit_count_q == 5'(WIN_HITS)) win_d = 1'b1;
      default: ;
    endcase
    if (new_game) begin
      wait_cnt_d   = 2'd0;
      sc_x_d       = 4'd0;
      sc_y_d       = 4'd0;
      sc_big_d     = 1'b0;
      big_left_d   = 2'(BIG_SHOTS);
      shots_left_d = 7'(MAX_SHOTS);
      hit_count_d  = 5'd0;
      last_d       = RES_NONE;
      win_d        = 1'b0;
      error_d      = 1'b0;
      reject_d     = 1'b0;
    end
  end

  // Outputs decoded from state or taken straight from registers.
  always_comb begin
    score_this     = (state_q == ST_ISSUE);
    result_valid   = (state_q == ST_REPORT);
    ready          = (state_q == ST_IDLE);
    game_over      = (state_q == ST_OVER);
    sc_x           = sc_x_q;
    sc_y           = sc_y_q;
    sc_big         = sc_big_q;
    sc_big_left    = big_left_q;
    shots_left     = shots_left_q;
    hit_count      = hit_count_q;
    last_hit       = (last_q == RES_HIT);
    last_near_miss = (last_q == RES_NEAR);
    last_miss      = (last_q == RES_MISS);
    win            = win_q;
    error          = error_q;
    reject         = reject_q;
  end

endmodule

// File: tb/tb_battleship_shot_ctrl.sv
// Bench for battleship_shot_ctrl: two instances (latency 1 / 60 shots, latency 3 / 2 shots)
// share all inputs; a per-instance game model predicts every pulse and counter.
// The scorer stimulus presents a different verdict in each WAIT slot to pin down sampling time.
module tb_battleship_shot_ctrl;

  localparam int BIGS = 3;
  localparam int WINH = 17;
  localparam logic [3:0] V_NONE = 4'b0000;
  localparam logic [3:0] V_HIT  = 4'b0100;
  localparam logic [3:0] V_NEAR = 4'b0010;
  localparam logic [3:0] V_MISS = 4'b0001;

  logic clock = 1'b0;
  logic reset, new_game, fire, big;
  logic sc_hit, sc_near_miss, sc_miss, sc_something_wrong;
  logic [3:0] x, y;

  logic       score_this [2];
  logic [3:0] sc_x [2];
  logic [3:0] sc_y [2];
  logic       sc_big [2];
  logic [1:0] sc_big_left [2];
  logic       ready [2];
  logic       result_valid [2];
  logic       last_hit [2];
  logic       last_near_miss [2];
  logic       last_miss [2];
  logic       reject [2];
  logic [6:0] shots_left [2];
  logic [4:0] hit_count [2];
  logic       game_over [2];
  logic       win [2];
  logic       error [2];

  int tests_run = 0;
  int tests_failed = 0;

  int lat  [2] = '{1, 3};
  int maxs [2] = '{60, 2};

  // Game model: remaining budgets, hits, last verdict (0 none, 1 hit, 2 near, 3 miss).
  int m_shots [2];
  int m_big   [2];
  int m_hits  [2];
  int m_last  [2];
  bit m_over  [2];
  bit m_win   [2];
  bit m_err   [2];

  always #5 clock = ~clock;

  battleship_shot_ctrl #(.RESULT_LAT(1), .BIG_SHOTS(3), .MAX_SHOTS(60), .WIN_HITS(17)) dut0 (
    .clock(clock), .reset(reset), .new_game(new_game), .fire(fire), .x(x), .y(y), .big(big),
    .sc_hit(sc_hit), .sc_near_miss(sc_near_miss), .sc_miss(sc_miss),
    .sc_something_wrong(sc_something_wrong), .score_this(score_this[0]), .sc_x(sc_x[0]),
    .sc_y(sc_y[0]), .sc_big(sc_big[0]), .sc_big_left(sc_big_left[0]), .ready(ready[0]),
    .result_valid(result_valid[0]), .last_hit(last_hit[0]), .last_near_miss(last_near_miss[0]),
    .last_miss(last_miss[0]), .reject(reject[0]), .shots_left(shots_left[0]),
    .hit_count(hit_count[0]), .game_over(game_over[0]), .win(win[0]), .error(error[0])
  );

  battleship_shot_ctrl #(.RESULT_LAT(3), .BIG_SHOTS(3), .MAX_SHOTS(2), .WIN_HITS(17)) dut1 (
    .clock(clock), .reset(reset), .new_game(new_game), .fire(fire), .x(x), .y(y), .big(big),
    .sc_hit(sc_hit), .sc_near_miss(sc_near_miss), .sc_miss(sc_miss),
    .sc_something_wrong(sc_something_wrong), .score_this(score_this[1]), .sc_x(sc_x[1]),
    .sc_y(sc_y[1]), .sc_big(sc_big[1]), .sc_big_left(sc_big_left[1]), .ready(ready[1]),
    .result_valid(result_valid[1]), .last_hit(last_hit[1]), .last_near_miss(last_near_miss[1]),
    .last_miss(last_miss[1]), .reject(reject[1]), .shots_left(shots_left[1]),
    .hit_count(hit_count[1]), .game_over(game_over[1]), .win(win[1]), .error(error[1])
  );

  function automatic int verdict_code(input logic [3:0] v);
    if (v[3]) return 0;
    case (v[2:0])
      3'b100:  return 1;
      3'b010:  return 2;
      3'b001:  return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] rand_verdict();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 4'b1100;
    if (r == 1) return 4'b0101;
    case (r % 3)
      0:       return V_HIT;
      1:       return V_NEAR;
      default: return V_MISS;
    endcase
  endfunction

  task automatic apply_verdict(input logic [3:0] v);
    {sc_something_wrong, sc_hit, sc_near_miss, sc_miss} = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_shots[i] = maxs[i];
      m_big[i]   = BIGS;
      m_hits[i]  = 0;
      m_last[i]  = 0;
      m_over[i]  = 1'b0;
      m_win[i]   = 1'b0;
      m_err[i]   = 1'b0;
    end
  endtask

  task automatic compare_model(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic [13:0] got_c, exp_c;
      logic [6:0]  got_f, exp_f;
      got_c = {shots_left[i], sc_big_left[i], hit_count[i]};
      exp_c = {7'(m_shots[i]), 2'(m_big[i]), 5'(m_hits[i])};
      tests_run++;
      if (got_c !== exp_c) begin
        tests_failed++;
        $display("FAIL %s dut%0d counters shots_left/big_left/hit_count: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 tag, i, shots_left[i], sc_big_left[i], hit_count[i], m_shots[i], m_big[i], m_hits[i]);
      end
      got_f = {game_over[i], win[i], error[i], ready[i], last_hit[i], last_near_miss[i], last_miss[i]};
      exp_f = {m_over[i], m_win[i], m_err[i], !m_over[i], m_last[i] == 1, m_last[i] == 2, m_last[i] == 3};
      tests_run++;
      if (got_f !== exp_f) begin
        tests_failed++;
        $display("FAIL %s dut%0d flags over/win/error/ready/hit/near/miss: got %b expected %b",
                 tag, i, got_f, exp_f);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic [18:0] got_f;
      got_f = {score_this[i], result_valid[i], reject[i], last_hit[i], last_near_miss[i], last_miss[i],
               game_over[i], win[i], error[i], sc_big[i], ready[i], sc_x[i], sc_y[i]};
      tests_run++;
      if (got_f !== 19'b0000000000_1_00000000) begin
        tests_failed++;
        $display("FAIL %s dut%0d reset outputs: got %b expected %b", tag, i, got_f, 19'b0000000000_1_00000000);
      end
      tests_run++;
      if ({shots_left[i], sc_big_left[i], hit_count[i]} !== {7'(maxs[i]), 2'(BIGS), 5'd0}) begin
        tests_failed++;
        $display("FAIL %s dut%0d reset counters: got %0d/%0d/%0d expected %0d/%0d/0",
                 tag, i, shots_left[i], sc_big_left[i], hit_count[i], maxs[i], BIGS);
      end
    end
  endtask

  // One fire request plus scorer replay; checks every cycle's strobes, then the end state.
  // Called just after a rising edge. Verdict slots va/vb/vc are presented in the WAIT cycles
  // that end with latency 1, 2 and 3 respectively.
  task automatic fire_shot(input string tag, input logic [3:0] fx, input logic [3:0] fy,
                           input logic fbig, input logic [3:0] va, input logic [3:0] vb,
                           input logic [3:0] vc, input bit hold);
    bit acc [2];
    bit rej [2];
    bit ok  [2];
    int code [2];
    int ncyc;
    logic [3:0] v;
    logic e_st, e_rj, e_rv;
    for (int i = 0; i < 2; i++) begin
      acc[i]  = !m_over[i] && fx <= 4'd9 && fy <= 4'd9 && (!fbig || m_big[i] > 0);
      rej[i]  = !m_over[i] && !acc[i];
      v       = (lat[i] == 1) ? va : (lat[i] == 2) ? vb : vc;
      code[i] = verdict_code(v);
      ok[i]   = acc[i] && code[i] != 0;
    end
    x = fx; y = fy; big = fbig; fire = 1'b1;
    ncyc = hold ? 20 : 6;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clock); #1;
      if (!hold || k == ncyc) fire = 1'b0;
      case (k)
        2:       apply_verdict(va);
        3:       apply_verdict(vb);
        4:       apply_verdict(vc);
        default: apply_verdict(V_NONE);
      endcase
      for (int i = 0; i < 2; i++) begin
        e_st = acc[i] && k == 1;
        e_rj = rej[i] && k == 1;
        e_rv = ok[i] && k == 2 + lat[i];
        tests_run++;
        if ({score_this[i], reject[i], result_valid[i]} !== {e_st, e_rj, e_rv}) begin
          tests_failed++;
          $display("FAIL %s dut%0d cycle %0d score_this/reject/result_valid: got %b%b%b expected %b%b%b",
                   tag, i, k, score_this[i], reject[i], result_valid[i], e_st, e_rj, e_rv);
        end
        if (acc[i] && k == 1) begin
          tests_run++;
          if ({sc_x[i], sc_y[i], sc_big[i]} !== {fx, fy, fbig}) begin
            tests_failed++;
            $display("FAIL %s dut%0d latched coords: got x=%0d y=%0d big=%b expected x=%0d y=%0d big=%b",
                     tag, i, sc_x[i], sc_y[i], sc_big[i], fx, fy, fbig);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        m_shots[i] = (m_shots[i] > 0) ? m_shots[i] - 1 : 0;
        if (fbig) m_big[i] = m_big[i] - 1;
        if (code[i] != 0) begin
          m_last[i] = code[i];
          if (code[i] == 1) m_hits[i] = m_hits[i] + 1;
          if (m_hits[i] == WINH) begin
            m_over[i] = 1'b1;
            m_win[i]  = 1'b1;
          end else if (m_shots[i] == 0) begin
            m_over[i] = 1'b1;
          end
        end else begin
          m_err[i]  = 1'b1;
          m_over[i] = 1'b1;
        end
      end
    end
    compare_model(tag);
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(posedge clock); #1;
    new_game = 1'b0;
    model_reset();
    compare_model("new_game");
  endtask

  task automatic test_reset();
    reset = 1'b1; new_game = 1'b0; fire = 1'b0; big = 1'b0; x = 4'd0; y = 4'd0;
    apply_verdict(V_NONE);
    #2;
    check_reset_values("reset_async");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check_reset_values("reset_release");
    model_reset();
  endtask

  task automatic test_basic_hit();
    fire_shot("basic_hit", 4'd3, 4'd4, 1'b0, V_HIT, V_HIT, V_HIT, 1'b0);
    tests_run++;
    if ({hit_count[0], shots_left[0], last_hit[0]} !== {5'd1, 7'd59, 1'b1}) begin
      tests_failed++;
      $display("FAIL basic_hit_summary: got hits=%0d shots=%0d last_hit=%b expected hits=1 shots=59 last_hit=1",
               hit_count[0], shots_left[0], last_hit[0]);
    end
  endtask

  task automatic test_big_shots();
    do_new_game();
    for (int n = 0; n < 4; n++) fire_shot("big_shot", 4'd1, 4'd2, 1'b1, V_MISS, V_NEAR, V_MISS, 1'b0);
  endtask

  task automatic test_out_of_range();
    do_new_game();
    fire_shot("x_out_of_range", 4'd10, 4'd2, 1'b0, V_HIT, V_HIT, V_HIT, 1'b0);
    fire_shot("y_out_of_range", 4'd5, 4'd15, 1'b0, V_HIT, V_HIT, V_HIT, 1'b0);
    fire_shot("corner", 4'd9, 4'd9, 1'b0, V_NEAR, V_HIT, V_NEAR, 1'b0);
  endtask

  task automatic test_fire_held();
    do_new_game();
    fire_shot("fire_held", 4'd7, 4'd0, 1'b0, V_MISS, V_MISS, V_MISS, 1'b1);
  endtask

  task automatic test_win();
    do_new_game();
    for (int n = 0; n < WINH; n++)
      fire_shot("win_run", 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 1'b0, V_HIT, V_MISS, V_HIT, 1'b0);
    fire_shot("after_win", 4'd2, 4'd2, 1'b0, V_HIT, V_HIT, V_HIT, 1'b0);
  endtask

  task automatic test_max_shots();
    do_new_game();
    fire_shot("max_shots", 4'd0, 4'd0, 1'b0, V_MISS, V_MISS, V_MISS, 1'b0);
    fire_shot("max_shots", 4'd8, 4'd1, 1'b0, V_MISS, V_MISS, V_MISS, 1'b0);
    do_new_game();
  endtask

  task automatic test_error();
    do_new_game();
    fire_shot("double_verdict", 4'd4, 4'd4, 1'b0, 4'b0101, 4'b0101, 4'b0101, 1'b0);
    do_new_game();
    fire_shot("wrong_flag", 4'd4, 4'd5, 1'b0, V_HIT, 4'b1010, 4'b1001, 1'b0);
  endtask

  task automatic test_abort();
    do_new_game();
    x = 4'd1; y = 4'd1; big = 1'b1; fire = 1'b1;
    @(posedge clock); #1;
    fire = 1'b0;
    new_game = 1'b1;
    @(posedge clock); #1;
    new_game = 1'b0;
    apply_verdict(V_HIT);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if ({score_this[i], result_valid[i]} !== 2'b00) begin
          tests_failed++;
          $display("FAIL abort dut%0d cycle %0d score_this/result_valid: got %b%b expected 00",
                   i, k, score_this[i], result_valid[i]);
        end
      end
      @(posedge clock); #1;
    end
    apply_verdict(V_NONE);
    model_reset();
    compare_model("abort");
  endtask

  task automatic test_reset_mid_wait();
    do_new_game();
    fire_shot("pre_reset", 4'd2, 4'd3, 1'b1, V_HIT, V_HIT, V_HIT, 1'b0);
    x = 4'd5; y = 4'd6; big = 1'b1; fire = 1'b1;
    @(posedge clock); #1;
    fire = 1'b0;
    @(posedge clock); #1;
    apply_verdict(V_HIT);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid_wait");
    apply_verdict(V_NONE);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    compare_model("after_reset");
  endtask

  task automatic test_random();
    do_new_game();
    for (int n = 0; n < 40; n++) begin
      fire_shot("random", 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                $urandom_range(0, 2) == 0, rand_verdict(), rand_verdict(), rand_verdict(), 1'b0);
      if ((m_over[0] || m_over[1]) && $urandom_range(0, 2) == 0) do_new_game();
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_big_shots();
    test_out_of_range();
    test_fire_held();
    test_win();
    test_max_shots();
    test_error();
    test_abort();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
